acos_phase: RTL and testbench

ACOS_PHASE -- requirements
Module: acos_phase

---
 rtl/acos_phase_pkg.sv | 38 +++
 rtl/acos_phase_cosine_quarter.sv | 45 ++++
 rtl/acos_phase.sv | 111 +++++++++++
 tb/tb_acos_phase.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/acos_phase_pkg.sv
// Shared constants, FSM encoding and quadrant mapping for the acos_phase
// coil-current phase estimator.
package acos_phase_pkg;

    localparam int PHASE_W     = 8;
    localparam int IDX_W       = 7;
    localparam int ITER_W      = 3;
    localparam int QUARTER     = 64;
    localparam int SEARCH_ITER = 7;
    localparam int LATENCY     = 16;

    // Last entry of the quarter-wave table; seeds the match flag for q=QUARTER.
    localparam logic [PHASE_W-1:0] C_LAST = 8'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_COMPARE = 2'd2,
        S_RESULT  = 2'd3
    } state_e;

    // Unfold a quarter index into the full revolution; the 9-bit sum wraps to 8 bits.
    function automatic logic [PHASE_W-1:0] map_quadrant(input logic [IDX_W-1:0] q,
                                                        input logic cos_neg,
                                                        input logic sin_neg);
        logic [PHASE_W:0] q9;
        logic [PHASE_W:0] sum;
        q9 = {2'b00, q};
        case ({cos_neg, sin_neg})
            2'b00:   sum = q9;
            2'b10:   sum = 9'd128 - q9;
            2'b11:   sum = 9'd128 + q9;
            default: sum = 9'd256 - q9;
        endcase
        return sum[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/acos_phase_cosine_quarter.sv
// Registered quarter-wave cosine ROM: entry i = round(255*cos(2*pi*i/256)), i = 0..64.
module cosine_quarter
    import acos_phase_pkg::*;
(
    input  logic               clk,
    input  logic [IDX_W-1:0]   addr,
    output logic [PHASE_W-1:0] data
);

    logic [PHASE_W-1:0] value;

    always_comb begin
        value = '0;
        case (addr)
            7'd0:  value = 8'd255;  7'd1:  value = 8'd255;  7'd2:  value = 8'd255;
            7'd3:  value = 8'd254;  7'd4:  value = 8'd254;  7'd5:  value = 8'd253;
            7'd6:  value = 8'd252;  7'd7:  value = 8'd251;  7'd8:  value = 8'd250;
            7'd9:  value = 8'd249;  7'd10: value = 8'd247;  7'd11: value = 8'd246;
            7'd12: value = 8'd244;  7'd13: value = 8'd242;  7'd14: value = 8'd240;
            7'd15: value = 8'd238;  7'd16: value = 8'd236;  7'd17: value = 8'd233;
            7'd18: value = 8'd231;  7'd19: value = 8'd228;  7'd20: value = 8'd225;
            7'd21: value = 8'd222;  7'd22: value = 8'd219;  7'd23: value = 8'd215;
            7'd24: value = 8'd212;  7'd25: value = 8'd208;  7'd26: value = 8'd205;
            7'd27: value = 8'd201;  7'd28: value = 8'd197;  7'd29: value = 8'd193;
            7'd30: value = 8'd189;  7'd31: value = 8'd185;  7'd32: value = 8'd180;
            7'd33: value = 8'd176;  7'd34: value = 8'd171;  7'd35: value = 8'd167;
            7'd36: value = 8'd162;  7'd37: value = 8'd157;  7'd38: value = 8'd152;
            7'd39: value = 8'd147;  7'd40: value = 8'd142;  7'd41: value = 8'd136;
            7'd42: value = 8'd131;  7'd43: value = 8'd126;  7'd44: value = 8'd120;
            7'd45: value = 8'd115;  7'd46: value = 8'd109;  7'd47: value = 8'd103;
            7'd48: value = 8'd98;   7'd49: value = 8'd92;   7'd50: value = 8'd86;
            7'd51: value = 8'd80;   7'd52: value = 8'd74;   7'd53: value = 8'd68;
            7'd54: value = 8'd62;   7'd55: value = 8'd56;   7'd56: value = 8'd50;
            7'd57: value = 8'd44;   7'd58: value = 8'd37;   7'd59: value = 8'd31;
            7'd60: value = 8'd25;   7'd61: value = 8'd19;   7'd62: value = 8'd13;
            7'd63: value = 8'd6;    7'd64: value = 8'd0;
            default: value = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= value;
    end

endmodule

// File: rtl/acos_phase.sv
// Inverse-cosine phase estimator: binary search of the quarter-wave table for
// the measured cosine magnitude, then quadrant unfolding from the channel signs.
module acos_phase
    import acos_phase_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [PHASE_W-1:0] cos_mag,
    input  logic               cos_neg,
    input  logic               sin_neg,
    output logic               busy,
    output logic               done,
    output logic [PHASE_W-1:0] phase,
    output logic               exact,
    output state_e             state
);

    state_e             next_state;
    logic [IDX_W-1:0]   lo;
    logic [IDX_W-1:0]   hi;
    logic [IDX_W-1:0]   mid;
    logic [IDX_W-1:0]   mid_calc;
    logic [ITER_W-1:0]  iter;
    logic [PHASE_W-1:0] val;
    logic               cneg;
    logic               sneg;
    logic               hi_eq;
    logic               accept;
    logic [PHASE_W-1:0] rom_q;

    cosine_quarter u_rom (
        .clk  (clk),
        .addr (mid_calc),
        .data (rom_q)
    );

    // Start is ignored during the done cycle so a held request restarts one cycle later.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        mid_calc   = 7'((8'(lo) + 8'(hi)) >> 1);
        case (state)
            S_IDLE: begin
                if (start && !done) begin
                    accept     = 1'b1;
                    next_state = S_LOOKUP;
                end
            end
            S_LOOKUP:  next_state = S_COMPARE;
            S_COMPARE: next_state = (iter == ITER_W'(SEARCH_ITER - 1)) ? S_RESULT : S_LOOKUP;
            S_RESULT:  next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            lo    <= '0;
            hi    <= '0;
            mid   <= '0;
            iter  <= '0;
            val   <= '0;
            cneg  <= 1'b0;
            sneg  <= 1'b0;
            hi_eq <= 1'b0;
            done  <= 1'b0;
            phase <= '0;
            exact <= 1'b0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        val   <= cos_mag;
                        cneg  <= cos_neg;
                        sneg  <= sin_neg;
                        lo    <= '0;
                        hi    <= IDX_W'(QUARTER);
                        iter  <= '0;
                        hi_eq <= (cos_mag == C_LAST);
                    end
                end
                S_LOOKUP: mid <= mid_calc;
                S_COMPARE: begin
                    iter <= iter + 1'b1;
                    // hi_eq tracks whether C(hi) matched exactly, so no extra ROM read is needed.
                    if (lo != hi) begin
                        if (rom_q <= val) begin
                            hi    <= mid;
                            hi_eq <= (rom_q == val);
                        end else begin
                            lo <= mid + 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    done  <= 1'b1;
                    phase <= map_quadrant(hi, cneg, sneg);
                    exact <= hi_eq;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_acos_phase.sv
// Scoreboard bench for acos_phase: random and directed conversions checked
// against a cosine-table model built from real arithmetic.
module tb_acos_phase;
    import acos_phase_pkg::*;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] cos_mag;
    logic       cos_neg;
    logic       sin_neg;
    logic       busy;
    logic       done;
    logic [7:0] phase;
    logic       exact;
    state_e     st;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ctab[65];

    logic [8:0] exp_q[$];
    int         acc_q[$];

    acos_phase dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .cos_mag (cos_mag),
        .cos_neg (cos_neg),
        .sin_neg (sin_neg),
        .busy    (busy),
        .done    (done),
        .phase   (phase),
        .exact   (exact),
        .state   (st)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: smallest quarter index whose cosine does not exceed the magnitude.
    function automatic logic [8:0] ref_model(input int m, input bit cn, input bit sn);
        int q;
        int p;
        q = 64;
        for (int i = 64; i >= 0; i--)
            if (ctab[i] <= m) q = i;
        if (!cn && !sn)     p = q;
        else if (cn && !sn) p = 128 - q;
        else if (cn && sn)  p = 128 + q;
        else                p = (256 - q) % 256;
        return {(ctab[q] == m) ? 1'b1 : 1'b0, 8'(p)};
    endfunction

    // monitor
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [8:0] e;
                int a;
                e = exp_q.pop_front();
                a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
                check("phase", phase, e[7:0]);
                check("exact", exact, e[8]);
                check("latency", cyc - a, LATENCY - 1);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) check("idle_timeout", 1, 0);
    endtask

    task automatic convert(input logic [7:0] m, input bit cn, input bit sn, input bit poke);
        wait_idle();
        @(negedge clk);
        cos_mag = m; cos_neg = cn; sin_neg = sn; start = 1'b1;
        exp_q.push_back(ref_model(m, cn, sn));
        @(posedge clk); #1;
        acc_q.push_back(cyc);
        check("busy_after_accept", busy, 1);
        start = 1'b0;
        cos_mag = 8'($urandom); cos_neg = 1'($urandom); sin_neg = 1'($urandom);
        if (poke) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic back_to_back(input logic [7:0] a, input logic [7:0] b);
        int n;
        wait_idle();
        @(negedge clk);
        cos_mag = a; cos_neg = 1'b0; sin_neg = 1'b0; start = 1'b1;
        exp_q.push_back(ref_model(a, 0, 0));
        @(posedge clk); #1;
        acc_q.push_back(cyc);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) check("b2b_done_timeout", 1, 0);
        cos_mag = b; cos_neg = 1'b1; sin_neg = 1'b1;
        exp_q.push_back(ref_model(b, 1, 1));
        @(posedge clk); #1;
        check("start_during_done_ignored", busy, 0);
        @(posedge clk); #1;
        check("start_after_done_accepted", busy, 1);
        acc_q.push_back(cyc);
        start = 1'b0;
    endtask

    task automatic reset_abort();
        wait_idle();
        @(negedge clk);
        cos_mag = 8'd200; cos_neg = 1'b1; sin_neg = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_phase", phase, 0);
        check("abort_exact", exact, 0);
        check("abort_state", st, S_IDLE);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (25) @(negedge clk);
        convert(8'd180, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i <= 64; i++)
            ctab[i] = $rtoi(255.0 * $cos(3.14159265358979 * i / 128.0) + 0.5);
        resetn = 1'b0; start = 1'b0; cos_mag = '0; cos_neg = 1'b0; sin_neg = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_phase", phase, 0);
        check("rst_exact", exact, 0);
        check("rst_state", st, S_IDLE);
        resetn = 1'b1;
        @(negedge clk);

        convert(8'd255, 0, 0, 0);
        convert(8'd0,   0, 0, 0);
        convert(8'd180, 1, 0, 0);
        convert(8'd100, 1, 1, 0);
        convert(8'd255, 0, 1, 1);
        convert(8'd0,   0, 1, 0);
        convert(8'd1,   1, 0, 0);
        convert(8'd254, 1, 1, 0);
        back_to_back(8'd98, 8'd97);
        reset_abort();
        for (int k = 0; k < 40; k++) begin
            convert(8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (20) @(negedge clk);
        check("pending_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
